// File: rtl/leitor_caminho_if.sv
// Bundle shared by the path reader and the blocks around it.
// Purpose: carries the start command (fonte/destino), the established-memory
// read port and the path-emission handshake.
// Modports:
//   slave  - the path reader (leitor_caminho)
//   master - controller, established memory and path consumer
interface leitor_caminho_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  construir_caminho_in;
  logic [ADDR_WIDTH-1:0] fonte_in;
  logic [ADDR_WIDTH-1:0] destino_in;
  logic                  ge_read_en_out;
  logic [ADDR_WIDTH-1:0] ge_read_addr_out;
  logic [DATA_WIDTH-1:0] ge_read_data_in;
  logic [ADDR_WIDTH-1:0] caminho_endereco_out;
  logic                  caminho_valido_out;
  logic                  caminho_ultimo_out;
  logic                  lido_in;
  logic                  caminho_pronto_out;
  logic                  erro_out;

  modport slave (
    input  construir_caminho_in, fonte_in, destino_in, ge_read_data_in, lido_in,
    output ge_read_en_out, ge_read_addr_out, caminho_endereco_out,
           caminho_valido_out, caminho_ultimo_out, caminho_pronto_out, erro_out
  );

  modport master (
    output construir_caminho_in, fonte_in, destino_in, ge_read_data_in, lido_in,
    input  ge_read_en_out, ge_read_addr_out, caminho_endereco_out,
           caminho_valido_out, caminho_ultimo_out, caminho_pronto_out, erro_out
  );
endinterface

// File: rtl/leitor_caminho.sv
// Path reader for the established-nodes memory.
// Purpose: on a construir_caminho pulse, walks predecessor links from destino
// back to fonte, emitting one node per valid/lido handshake, then pulses
// pronto or raises a sticky erro (node never established, or loop guard hit).
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - leitor_caminho_if.slave: start command, memory read port,
//            path handshake and status outputs
//
// state  | meaning
// OCIOSO | idle, waiting for construir_caminho
// LER    | read enable asserted for node atual
// ESPERA | memory data arrives, capture predecessor and flag
// EMITIR | node atual offered on the path port until lido
// PRONTO | one-cycle path-complete pulse
// ERRO   | broken path or loop, erro held until next start
module leitor_caminho #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  leitor_caminho_if.slave   bus
);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    LER    = 3'd1,
    ESPERA = 3'd2,
    EMITIR = 3'd3,
    PRONTO = 3'd4,
    ERRO   = 3'd5
  } estado_t;

  // passos counts accepted nodes; reaching 2**ADDR_WIDTH means a cycle.
  localparam logic [ADDR_WIDTH:0] PASSO_UM   = 1;
  localparam logic [ADDR_WIDTH:0] PASSOS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  estado_t               estado_q;
  logic [ADDR_WIDTH-1:0] atual_q;
  logic [ADDR_WIDTH-1:0] fonte_q;
  logic [ADDR_WIDTH-1:0] anterior_q;
  logic                  flag_q;
  logic [ADDR_WIDTH:0]   passos_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  valido_q;
  logic                  ultimo_q;
  logic                  pronto_q;
  logic                  erro_q;
  logic                  aceite;

  // valido_q is only ever high in EMITIR, so it alone qualifies the handshake.
  assign aceite = valido_q & bus.lido_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      atual_q    <= '0;
      fonte_q    <= '0;
      anterior_q <= '0;
      flag_q     <= 1'b0;
      passos_q   <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      valido_q   <= 1'b0;
      ultimo_q   <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      rd_en_q  <= 1'b0;
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO, ERRO: begin
          if (bus.construir_caminho_in) begin
            fonte_q   <= bus.fonte_in;
            atual_q   <= bus.destino_in;
            passos_q  <= '0;
            erro_q    <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= bus.destino_in;
            estado_q  <= LER;
          end
        end
        LER: begin
          estado_q <= ESPERA;
        end
        ESPERA: begin
          anterior_q <= bus.ge_read_data_in[ADDR_WIDTH-1:0];
          flag_q     <= bus.ge_read_data_in[ADDR_WIDTH];
          valido_q   <= 1'b1;
          ultimo_q   <= (atual_q == fonte_q);
          estado_q   <= EMITIR;
        end
        EMITIR: begin
          if (aceite) begin
            valido_q <= 1'b0;
            ultimo_q <= 1'b0;
            passos_q <= passos_q + PASSO_UM;
            if (atual_q == fonte_q) begin
              pronto_q <= 1'b1;
              estado_q <= PRONTO;
            end else if (!flag_q) begin
              erro_q   <= 1'b1;
              estado_q <= ERRO;
            end else if ((passos_q + PASSO_UM) == PASSOS_MAX) begin
              erro_q   <= 1'b1;
              estado_q <= ERRO;
            end else begin
              atual_q   <= anterior_q;
              rd_en_q   <= 1'b1;
              rd_addr_q <= anterior_q;
              estado_q  <= LER;
            end
          end
        end
        PRONTO: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.ge_read_en_out       = rd_en_q;
  assign bus.ge_read_addr_out     = rd_addr_q;
  assign bus.caminho_endereco_out = atual_q;
  assign bus.caminho_valido_out   = valido_q;
  assign bus.caminho_ultimo_out   = ultimo_q;
  assign bus.caminho_pronto_out   = pronto_q;
  assign bus.erro_out             = erro_q;

  // Memory word bits above the flag carry nothing for this reader.
  generate
    if (DATA_WIDTH > ADDR_WIDTH + 1) begin : g_bits_livres
      logic unused_bits;
      assign unused_bits = ^bus.ge_read_data_in[DATA_WIDTH-1:ADDR_WIDTH+1];
    end
  endgenerate

endmodule

// File: tb/tb_leitor_caminho.sv
module tb_leitor_caminho;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int NODES = 1 << AW;
  localparam int MAXC  = 800;

  logic clk;
  logic rst_n;

  leitor_caminho_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  leitor_caminho #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Established memory: one-cycle read latency.
  bit mem_flag [NODES];
  int mem_pred [NODES];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1]   = 1'($urandom);
    w[AW]     = mem_flag[a];
    w[AW-1:0] = mem_pred[a][AW-1:0];
    return w;
  endfunction

  always @(posedge clk)
    if (bus.ge_read_en_out) bus.ge_read_data_in <= mem_word(bus.ge_read_addr_out);

  logic [2*AW+4:0] outs;
  assign outs = {bus.ge_read_en_out, bus.ge_read_addr_out, bus.caminho_endereco_out,
                 bus.caminho_valido_out, bus.caminho_ultimo_out,
                 bus.caminho_pronto_out, bus.erro_out};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model results
  int exp_nodes[$];
  int exp_ult[$];
  int exp_cyc[$];
  bit exp_ok;
  int exp_pronto_cyc;

  // Observations
  int obs_nodes[$];
  int obs_ult[$];
  int obs_cyc[$];
  int obs_rd[$];
  int obs_pronto_cyc;
  int obs_pronto_n;
  bit obs_erro;
  bit obs_erro_sticky;
  logic obs_erro_c1;
  bit obs_stable;
  bit obs_timeout;

  function automatic bit same_q(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Path from destino: visit nodes until fonte, a non-established node,
  // or NODES visits. Timing: first node in cycle 3, each next node w+3 later.
  function automatic void model(input int f, input int d, input int w);
    int cur;
    exp_nodes.delete(); exp_ult.delete(); exp_cyc.delete();
    exp_ok = 1'b0;
    cur = d;
    for (int k = 0; k < NODES; k++) begin
      exp_nodes.push_back(cur);
      exp_ult.push_back(int'(cur == f));
      exp_cyc.push_back(3 + k * (w + 3));
      if (cur == f) begin exp_ok = 1'b1; break; end
      if (!mem_flag[cur]) break;
      cur = mem_pred[cur];
    end
    exp_pronto_cyc = exp_ok ? exp_cyc[exp_cyc.size()-1] + w + 1 : -1;
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < NODES; i++) begin
      mem_flag[i] = 1'b0;
      mem_pred[i] = 0;
    end
  endfunction

  // Starts a walk and records what the DUT does. w=0 holds lido high
  // throughout; w>0 raises lido w cycles after each node becomes valid.
  // inj pulses a competing start while the first node waits.
  task automatic run_walk(input int f, input int d, input int w, input bit inj);
    int cyc, wait_cnt, erro_cyc, held_node, held_ult;
    bit done;
    obs_nodes.delete(); obs_ult.delete(); obs_cyc.delete(); obs_rd.delete();
    obs_pronto_cyc = -1; obs_pronto_n = 0; obs_erro = 0; obs_erro_sticky = 1;
    obs_erro_c1 = 1'bx; obs_stable = 1; obs_timeout = 0;
    held_node = 0; held_ult = 0;
    @(negedge clk);
    bus.fonte_in = AW'(f);
    bus.destino_in = AW'(d);
    bus.construir_caminho_in = 1'b1;
    bus.lido_in = (w == 0);
    @(negedge clk);
    bus.construir_caminho_in = 1'b0;
    bus.fonte_in = AW'($urandom);
    bus.destino_in = AW'($urandom);
    cyc = 1; wait_cnt = 0; erro_cyc = -1; done = 0;
    while (!done) begin
      if (cyc == 1) obs_erro_c1 = bus.erro_out;
      bus.construir_caminho_in = 1'b0;
      if (bus.ge_read_en_out) obs_rd.push_back(int'(bus.ge_read_addr_out));
      if (bus.caminho_pronto_out) begin
        obs_pronto_n++;
        if (obs_pronto_cyc < 0) obs_pronto_cyc = cyc;
      end
      if (bus.erro_out) begin
        if (erro_cyc < 0) erro_cyc = cyc;
        obs_erro = 1;
      end else if (erro_cyc >= 0) obs_erro_sticky = 0;
      if (bus.caminho_valido_out) begin
        if (wait_cnt == 0) begin
          held_node = int'(bus.caminho_endereco_out);
          held_ult  = int'(bus.caminho_ultimo_out);
          obs_nodes.push_back(held_node);
          obs_ult.push_back(held_ult);
          obs_cyc.push_back(cyc);
        end else if (int'(bus.caminho_endereco_out) != held_node ||
                     int'(bus.caminho_ultimo_out) != held_ult) obs_stable = 0;
        if (inj && obs_nodes.size() == 1 && wait_cnt == 1) begin
          bus.construir_caminho_in = 1'b1;
          bus.fonte_in = AW'(7);
          bus.destino_in = AW'(7);
        end
        if (w > 0) bus.lido_in = (wait_cnt >= w);
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (w > 0) bus.lido_in = 1'b0;
      end
      if (obs_pronto_cyc >= 0 && cyc >= obs_pronto_cyc + 2) done = 1;
      if (erro_cyc >= 0 && cyc >= erro_cyc + 5) done = 1;
      if (cyc >= MAXC) begin obs_timeout = 1; done = 1; end
      if (!done) begin @(negedge clk); cyc++; end
    end
    bus.lido_in = 1'b0;
    bus.construir_caminho_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.construir_caminho_in = 1'b0;
    bus.lido_in = 1'b0;
    bus.fonte_in = '0;
    bus.destino_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", outs); end
  endtask

  task automatic set_path_531();
    clear_mem();
    mem_flag[5] = 1; mem_pred[5] = 3;
    mem_flag[3] = 1; mem_pred[3] = 1;
    mem_flag[1] = 0; mem_pred[1] = 2;
  endtask

  task automatic test_basic_path();
    set_path_531();
    model(1, 5, 0);
    run_walk(1, 5, 0, 0);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes)) begin n_fail++; $display("FAIL basic_nodes: got %p want %p", obs_nodes, exp_nodes); end
    n_checks++;
    if (!same_q(obs_cyc, exp_cyc)) begin n_fail++; $display("FAIL basic_node_cycles: got %p want %p", obs_cyc, exp_cyc); end
    n_checks++;
    if (!same_q(obs_ult, exp_ult)) begin n_fail++; $display("FAIL basic_ultimo: got %p want %p", obs_ult, exp_ult); end
    n_checks++;
    if (!same_q(obs_rd, exp_nodes)) begin n_fail++; $display("FAIL basic_reads: got %p want %p", obs_rd, exp_nodes); end
    n_checks++;
    if (obs_pronto_cyc != exp_pronto_cyc || obs_pronto_n != 1) begin
      n_fail++; $display("FAIL basic_pronto: got cycle %0d count %0d want cycle %0d count 1", obs_pronto_cyc, obs_pronto_n, exp_pronto_cyc);
    end
    n_checks++;
    if (obs_erro !== 1'b0 || obs_timeout) begin n_fail++; $display("FAIL basic_erro: got erro %0d timeout %0d want 0 0", obs_erro, obs_timeout); end
  endtask

  task automatic test_slow_lido();
    set_path_531();
    model(1, 5, 4);
    run_walk(1, 5, 4, 1);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes)) begin n_fail++; $display("FAIL slow_nodes: got %p want %p", obs_nodes, exp_nodes); end
    n_checks++;
    if (!same_q(obs_cyc, exp_cyc)) begin n_fail++; $display("FAIL slow_node_cycles: got %p want %p", obs_cyc, exp_cyc); end
    n_checks++;
    if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL slow_hold_stable: got %0d want 1", obs_stable); end
    n_checks++;
    if (!same_q(obs_rd, exp_nodes)) begin n_fail++; $display("FAIL slow_reads: got %p want %p", obs_rd, exp_nodes); end
    n_checks++;
    if (!same_q(obs_ult, exp_ult) || obs_pronto_cyc != exp_pronto_cyc) begin
      n_fail++; $display("FAIL slow_ultimo_pronto: got %p pronto %0d want %p pronto %0d", obs_ult, obs_pronto_cyc, exp_ult, exp_pronto_cyc);
    end
  endtask

  task automatic test_single_node();
    clear_mem();
    mem_flag[7] = 0; mem_pred[7] = 12;
    model(7, 7, 0);
    run_walk(7, 7, 0, 0);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes) || !same_q(obs_ult, exp_ult)) begin
      n_fail++; $display("FAIL single_node: got %p ult %p want %p ult %p", obs_nodes, obs_ult, exp_nodes, exp_ult);
    end
    n_checks++;
    if (obs_pronto_cyc != exp_pronto_cyc || obs_erro !== 1'b0) begin
      n_fail++; $display("FAIL single_pronto: got pronto %0d erro %0d want pronto %0d erro 0", obs_pronto_cyc, obs_erro, exp_pronto_cyc);
    end
    n_checks++;
    if (!same_q(obs_rd, exp_nodes)) begin n_fail++; $display("FAIL single_read: got %p want %p", obs_rd, exp_nodes); end
  endtask

  task automatic test_broken();
    clear_mem();
    mem_flag[5] = 0; mem_pred[5] = 2;
    mem_flag[2] = 1; mem_pred[2] = 1;
    model(1, 5, 0);
    run_walk(1, 5, 0, 0);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes)) begin n_fail++; $display("FAIL broken_nodes: got %p want %p", obs_nodes, exp_nodes); end
    n_checks++;
    if (obs_erro !== !exp_ok || obs_erro_sticky !== 1'b1 || obs_pronto_n != 0) begin
      n_fail++; $display("FAIL broken_erro: got erro %0d sticky %0d pronto %0d want erro 1 sticky 1 pronto 0", obs_erro, obs_erro_sticky, obs_pronto_n);
    end
    n_checks++;
    if (!same_q(obs_rd, exp_nodes)) begin n_fail++; $display("FAIL broken_reads: got %p want %p", obs_rd, exp_nodes); end
    run_walk(5, 5, 0, 0);
    n_checks++;
    if (obs_erro_c1 !== 1'b0 || obs_pronto_n != 1) begin
      n_fail++; $display("FAIL restart_clears_erro: got erro %b pronto %0d want erro 0 pronto 1", obs_erro_c1, obs_pronto_n);
    end
  endtask

  task automatic test_self_loop();
    clear_mem();
    mem_flag[9] = 1; mem_pred[9] = 9;
    model(0, 9, 0);
    run_walk(0, 9, 0, 0);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes)) begin n_fail++; $display("FAIL loop_nodes: got %0d nodes want %0d", obs_nodes.size(), exp_nodes.size()); end
    n_checks++;
    if (obs_erro !== 1'b1 || obs_pronto_n != 0 || obs_timeout) begin
      n_fail++; $display("FAIL loop_erro: got erro %0d pronto %0d timeout %0d want 1 0 0", obs_erro, obs_pronto_n, obs_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  bad;
    set_path_531();
    @(negedge clk);
    bus.fonte_in = AW'(1);
    bus.destino_in = AW'(5);
    bus.construir_caminho_in = 1'b1;
    bus.lido_in = 1'b0;
    @(negedge clk);
    bus.construir_caminho_in = 1'b0;
    n = 0;
    while (!bus.caminho_valido_out && n < 10) begin @(negedge clk); n++; end
    n_checks++;
    if (bus.caminho_valido_out !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_emit: got valido %b want 1", bus.caminho_valido_out); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (outs !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midreset_quiet: got activity %0d want 0", bad); end
    model(1, 5, 0);
    run_walk(1, 5, 0, 0);
    n_checks++;
    if (!same_q(obs_nodes, exp_nodes) || obs_pronto_cyc != exp_pronto_cyc) begin
      n_fail++; $display("FAIL midreset_rerun: got %p pronto %0d want %p pronto %0d", obs_nodes, obs_pronto_cyc, exp_nodes, exp_pronto_cyc);
    end
  endtask

  task automatic test_random();
    int f, d, w, cur, len;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NODES; i++) begin
        mem_flag[i] = ($urandom_range(0, 5) != 0);
        mem_pred[i] = $urandom_range(0, NODES - 1);
      end
      d = $urandom_range(0, NODES - 1);
      f = $urandom_range(0, NODES - 1);
      if (it % 2 == 0) begin
        cur = d;
        len = $urandom_range(1, 10);
        for (int k = 0; k < len; k++) begin
          mem_flag[cur] = 1'b1;
          mem_pred[cur] = $urandom_range(0, NODES - 1);
          cur = mem_pred[cur];
        end
        f = cur;
      end
      w = $urandom_range(0, 3);
      model(f, d, w);
      run_walk(f, d, w, 0);
      n_checks++;
      if (!same_q(obs_nodes, exp_nodes) || !same_q(obs_ult, exp_ult)) begin
        n_fail++; $display("FAIL rand%0d_nodes: got %p want %p", it, obs_nodes, exp_nodes);
      end
      n_checks++;
      if (!same_q(obs_cyc, exp_cyc) || !same_q(obs_rd, exp_nodes)) begin
        n_fail++; $display("FAIL rand%0d_timing_reads: got cycles %p reads %p want cycles %p", it, obs_cyc, obs_rd, exp_cyc);
      end
      n_checks++;
      if (obs_erro !== !exp_ok || obs_pronto_cyc != exp_pronto_cyc || obs_timeout) begin
        n_fail++; $display("FAIL rand%0d_outcome: got erro %0d pronto %0d want erro %0d pronto %0d", it, obs_erro, obs_pronto_cyc, !exp_ok, exp_pronto_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_path();
    test_slow_lido();
    test_single_node();
    test_broken();
    test_self_loop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leitor_caminho.md
Name: leitor_caminho

Overview:
- Reader side of the established-nodes memory (gerenciador_estabelecidos), which the neighbour locator writes during expansion.
- On the controller's construir_caminho command, follows predecessor links from destino back to fonte.
- Emits the path one node per valid/lido handshake, then reports path complete or error to controlador_maquina_estados.

Parameters:
- ADDR_WIDTH, 6, node address width; the graph holds 2**ADDR_WIDTH nodes.
- DATA_WIDTH, 8, established-memory word width. Must be >= ADDR_WIDTH+1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- construir_caminho_in  input  1  single-cycle start pulse from the controller
- fonte_in  input  ADDR_WIDTH  source node; sampled at start
- destino_in  input  ADDR_WIDTH  destination node; sampled at start
- ge_read_en_out  output  1  established-memory read enable
- ge_read_addr_out  output  ADDR_WIDTH  established-memory read address
- ge_read_data_in  input  DATA_WIDTH  read data, valid the cycle after ge_read_en_out
  - bit [ADDR_WIDTH] = established flag
  - bits [ADDR_WIDTH-1:0] = predecessor (anterior)
- caminho_endereco_out  output  ADDR_WIDTH  current path node
- caminho_valido_out  output  1  caminho_endereco_out is valid
- caminho_ultimo_out  output  1  current node is fonte (last node of the path)
- lido_in  input  1  consumer accepted the node (handshake completes when valido and lido are both high)
- caminho_pronto_out  output  1  one-cycle pulse after the last node is accepted
- erro_out  output  1  path broken or loop detected; sticky until the next start

Behaviour:
- Reset: every output 0; state OCIOSO; internal registers atual, fonte_r, anterior_r and passos cleared.
- Reset asserted mid-operation aborts the walk immediately; no pronto or erro is produced.
- States: OCIOSO, LER, ESPERA, EMITIR, PRONTO, ERRO.
- OCIOSO or ERRO, with construir_caminho_in=1:
  - fonte_r <= fonte_in; atual <= destino_in; passos <= 0; erro_out <= 0; next state LER.
- construir_caminho_in is ignored in LER, ESPERA, EMITIR and PRONTO.
- LER (1 cycle): ge_read_en_out=1, ge_read_addr_out=atual; next state ESPERA.
  - In all other states ge_read_en_out=0 and ge_read_addr_out holds its last value.
- ESPERA (1 cycle): anterior_r <= ge_read_data_in[ADDR_WIDTH-1:0]; valid_r <= ge_read_data_in[ADDR_WIDTH]; next state EMITIR.
- EMITIR:
  - caminho_valido_out=1, caminho_endereco_out=atual, caminho_ultimo_out=(atual==fonte_r).
  - Outputs are held stable until lido_in=1. lido_in while not valid is ignored.
- On handshake in EMITIR, passos <= passos+1, then:
  - if atual==fonte_r: next state PRONTO.
  - else if valid_r==0: next state ERRO (node was never established).
  - else if passos+1 == 2**ADDR_WIDTH: next state ERRO (loop guard; passos is ADDR_WIDTH+1 bits wide).
  - else: atual <= anterior_r; next state LER.
- PRONTO (1 cycle): caminho_pronto_out=1; next state OCIOSO.
- ERRO: erro_out=1 and the state is held until the next start. caminho_valido_out=0.
- Latency:
  - Start at edge 0: read issued in cycle 1; first node valid from cycle 3.
  - Handshake at edge t: next node valid at t+3.
  - With lido held high, one node is emitted every 3 cycles.
- fonte==destino: a single node is emitted with caminho_ultimo_out=1, followed by pronto. The read is still issued and its data is ignored.
- The fonte entry's data, including its flag, is never checked.
- All outputs are registered or decoded from the registered state only; no combinational path from lido_in to any output.

Test Plan:
- Memory [5]={1,3}, [3]={1,1}; fonte=1, destino=5; lido held 1 -> nodes 5, 3, 1 at cycles 3, 6, 9; ultimo=1 only with node 1; pronto pulse at cycle 10; reads observed at addresses 5, 3, 1.
- Same path with lido asserted only 4 cycles after each valid -> node and ultimo held stable while waiting; no extra reads; same node sequence.
- fonte=destino=7 -> single node 7 with ultimo=1, then pronto; erro=0.
- Memory [5]={0,2}; fonte=1, destino=5 -> node 5 emitted; after lido, erro=1 and stays 1; no further reads; a new start clears erro.
- Memory [9]={1,9}, fonte=0, destino=9 (self-loop) -> node 9 emitted 64 times, then erro=1; no pronto.
- rst_n low during EMITIR -> all outputs 0 at once; a start after reset runs normally. A start pulse during EMITIR is ignored: the path and the fonte/destino in use are unchanged.
